// File: rtl/grey_pkg.sv
// Shared helpers for the Gray decoder: integer ceiling divide and bit count.
package grey_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Callers zero-extend into the 64-bit argument.
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/grey_decode_stage.sv
// One decoder pipeline stage: resolves binary bits HI..LO and registers the beat.
module grey_decode_stage #(
  parameter int N  = 4,
  parameter int HI = 3,
  parameter int LO = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  input  logic         i_err,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  output logic         o_err
);

  logic         vld_q, err_q, ld;
  logic [N-1:0] dat_q, dat_d;

  // Bits above HI are already binary, bits at or below are still Gray;
  // bit N-1 is identical in both codes so it never needs work.
  always_comb begin
    dat_d = i_data;
    for (int k = N - 2; k >= 0; k--)
      if (k <= HI && k >= LO) dat_d[k] = dat_d[k+1] ^ i_data[k];
  end

  assign ld = !vld_q || i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else if (ld) begin
      vld_q <= i_valid;
      if (i_valid) begin
        dat_q <= dat_d;
        err_q <= i_err;
      end
    end
  end

  assign o_valid = vld_q;
  assign o_data  = dat_q;
  assign o_err   = err_q;

endmodule

// File: rtl/grey_decoder_nbit_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control and an
// optional single-bit-step checker on the accepted code stream.
module grey_decoder_nbit_pipe
  import grey_pkg::*;
#(
  parameter int N         = 4,
  parameter int STAGES    = 2,
  parameter int CHECK_ADJ = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_grey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_bin,
  output logic         o_err
);

  localparam int CH = ceil_div(N, STAGES);

  logic [STAGES:0]        vld, err;
  logic [STAGES:0][N-1:0] dat;
  logic [STAGES-1:0]      dn_rdy;
  logic                   adj_err;

  assign vld[0] = i_valid & i_en;
  assign dat[0] = i_grey;
  assign err[0] = adj_err;

  // Stage s may load when any later stage is empty or the sink takes a beat;
  // written flat from the valids so ready never feeds back on itself.
  always_comb begin
    dn_rdy[STAGES-1] = i_ready;
    for (int s = STAGES - 2; s >= 0; s--)
      dn_rdy[s] = dn_rdy[s+1] | ~vld[s+2];
  end

  assign o_ready = i_en & (~vld[1] | dn_rdy[0]);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int HI = N - 1 - s * CH;
    localparam int LO = (N - (s + 1) * CH > 0) ? N - (s + 1) * CH : 0;
    grey_decode_stage #(.N(N), .HI(HI), .LO(LO)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (vld[s]),
      .i_data  (dat[s]),
      .i_err   (err[s]),
      .i_ready (dn_rdy[s]),
      .o_valid (vld[s+1]),
      .o_data  (dat[s+1]),
      .o_err   (err[s+1])
    );
  end

  if (CHECK_ADJ != 0) begin : g_chk
    logic [N-1:0] prev_q;
    logic         prev_vld_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        prev_q     <= '0;
        prev_vld_q <= 1'b0;
      end else if (i_valid && o_ready) begin
        prev_q     <= i_grey;
        prev_vld_q <= 1'b1;
      end
    end

    // A repeated code (distance 0) is a legal resample.
    assign adj_err = prev_vld_q && (popcount(64'(i_grey ^ prev_q)) > 1);
  end else begin : g_nochk
    assign adj_err = 1'b0;
  end

  assign o_valid = vld[STAGES];
  assign o_bin   = dat[STAGES];
  assign o_err   = err[STAGES];

endmodule

// File: tb/tb_grey_decoder_nbit_pipe.sv
// Bench: directed Gray decode cases plus randomized handshake traffic against a queue model.
module tb_grey_decoder_nbit_pipe;
  localparam int N  = 4;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst_n, en, valid, rdy;
  logic [N-1:0] grey;
  logic ready, ov, err;
  logic [N-1:0] bin;

  logic en8, v8, rdy8;
  logic [7:0] g8;
  logic r8, ov8, err8;
  logic [7:0] bin8;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grey_decoder_nbit_pipe #(.N(N), .STAGES(ST), .CHECK_ADJ(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .o_ready(ready),
    .i_grey(grey), .o_valid(ov), .i_ready(rdy), .o_bin(bin), .o_err(err)
  );

  grey_decoder_nbit_pipe #(.N(8), .STAGES(3), .CHECK_ADJ(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en8), .i_valid(v8), .o_ready(r8),
    .i_grey(g8), .o_valid(ov8), .i_ready(rdy8), .o_bin(bin8), .o_err(err8)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference model: every accepted beat is queued with its decoded value,
  // adjacency flag and accept cycle; the sink must see them in queue order.
  typedef struct {
    logic [N-1:0] b;
    logic         e;
    int           acc;
  } beat_t;

  beat_t        q[$];
  logic [N-1:0] m_prev;
  bit           m_prev_vld = 0;
  int           last_lo = -1;
  int           m_lat;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b ^= g >> i;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_prev_vld = 0;
      chk("rst_o_valid", ov, 0);
      chk("rst_o_bin", bin, 0);
      chk("rst_o_err", err, 0);
    end else begin
      chk("o_ready", ready, en & (rdy | (q.size() < ST)));
      if (ov) begin
        if (q.size() == 0) chk("spurious_o_valid", ov, 0);
        else begin
          chk("o_bin", bin, q[0].b);
          chk("o_err", err, q[0].e);
          m_lat = cyc - q[0].acc;
          chk("latency_min", m_lat >= ST, 1);
          if (q[0].acc > last_lo) chk("latency", m_lat, ST);
          if (rdy) void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].acc > last_lo && cyc - q[0].acc >= ST)
        chk("late_o_valid", ov, 1);
      if (valid && ready) begin
        q.push_back('{g2b(grey), m_prev_vld && ($countones(grey ^ m_prev) > 1), cyc});
        m_prev     = grey;
        m_prev_vld = 1;
      end
      if (!rdy) last_lo = cyc;
    end
  end

  // Streaming Gray codes 0..15 must decode to the plain count.
  bit t1_on = 0;
  int t1_idx = 0;
  always @(negedge clk) begin
    if (t1_on && rst_n && ov && rdy) begin
      chk("t1_seq", bin, t1_idx);
      chk("t1_err", err, 0);
      t1_idx++;
    end
  end

  task automatic send(input logic [N-1:0] g);
    valid = 1'b1;
    grey  = g;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk); #1;
        valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_timeout", 0, 1);
    valid = 1'b0;
  endtask

  task automatic wait_out(input logic [N-1:0] eb, input logic ee, input string nm);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ov && rdy) begin
        chk({nm, "_bin"}, bin, eb);
        chk({nm, "_err"}, err, ee);
        return;
      end
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  logic [N-1:0] bp_codes [3];
  int           bp_n;
  bit           acc_r;

  initial begin
    rst_n = 0; en = 1; valid = 0; rdy = 1; grey = '0;
    en8 = 1; v8 = 0; rdy8 = 1; g8 = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Test 1: back-to-back Gray count.
    t1_on = 1;
    for (int i = 0; i < 16; i++) send(N'(i ^ (i >> 1)));
    repeat (4) @(posedge clk);
    #1;
    t1_on = 0;
    chk("t1_count", t1_idx, 16);

    // Test 2: single beat; previous code 1000 is three bits away.
    send(4'b0110);
    wait_out(4'b0100, 1'b1, "t2");
    @(posedge clk); #1;

    // Test 4: back-pressure holds two beats and freezes the output.
    bp_codes[0] = 4'b0101; bp_codes[1] = 4'b0100; bp_codes[2] = 4'b1100;
    bp_n = 0;
    rdy = 0; valid = 1; grey = bp_codes[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("bp_o_ready", ready, 0);
        chk("bp_o_valid", ov, 1);
        chk("bp_o_bin", bin, 4'b0110);
      end
      acc_r = valid & ready;
      @(posedge clk); #1;
      if (acc_r) begin
        bp_n++;
        grey = bp_codes[bp_n];
      end
    end
    chk("bp_held", bp_n, 2);
    rdy = 1;
    for (int c = 0; c < 20 && bp_n < 3; c++) begin
      @(negedge clk);
      acc_r = valid & ready;
      @(posedge clk); #1;
      if (acc_r) bp_n++;
    end
    valid = 0;
    chk("bp_all_accepted", bp_n, 3);
    repeat (4) @(posedge clk);
    #1;

    // i_en low blocks acceptance even with i_valid high.
    en = 0; valid = 1; grey = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("en0_o_ready", ready, 0);
      @(posedge clk); #1;
    end
    valid = 0; en = 1;

    // Randomized traffic: random sink stalls, enable drops and code steps.
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) != 0);
      if (!valid && $urandom_range(0, 1) == 1) begin
        valid = 1;
        if ($urandom_range(0, 3) == 0) grey = N'($urandom);
        else grey = grey ^ (4'b0001 << $urandom_range(0, 3));
      end
      @(negedge clk);
      acc_r = valid & ready;
      @(posedge clk); #1;
      if (acc_r) valid = 0;
    end
    valid = 0; en = 1; rdy = 1;
    repeat (6) @(posedge clk);
    #1;

    // Test 5: reset with beats in flight.
    send(4'b0001);
    send(4'b0011);
    rst_n = 0;
    #1;
    chk("arst_o_valid", ov, 0);
    chk("arst_o_bin", bin, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    send(4'b1111);
    wait_out(4'b1010, 1'b0, "t5");
    @(posedge clk); #1;

    // Test 3: 0100 -> 0000 is adjacent, 0000 -> 0011 is not.
    fork
      begin
        send(4'b0100);
        send(4'b0000);
        send(4'b0011);
      end
      begin
        wait_out(4'b0111, 1'b1, "t3a");
        wait_out(4'b0000, 1'b0, "t3b");
        wait_out(4'b0010, 1'b1, "t3c");
      end
    join
    @(posedge clk); #1;

    // Test 6: 8-bit, three-stage instance.
    v8 = 1; g8 = 8'hFF;
    @(negedge clk);
    chk("t6_o_ready", r8, 1);
    @(posedge clk); #1;
    v8 = 0;
    @(negedge clk);
    chk("t6_early1", ov8, 0);
    @(negedge clk);
    chk("t6_early2", ov8, 0);
    @(negedge clk);
    chk("t6_o_valid", ov8, 1);
    chk("t6_o_bin", bin8, 8'hAA);
    chk("t6_o_err", err8, 0);
    @(posedge clk); #1;
    en8 = 0; v8 = 1; g8 = 8'h00;
    @(negedge clk);
    chk("t6_en0_o_ready", r8, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_en0_no_beat", ov8, 0);
    v8 = 0; en8 = 1;

    // Drain and confirm nothing is left in the model.
    for (int c = 0; c < 20 && q.size() > 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
